watch_set_ctrl: RTL
===================

WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 655, button stable time in clk_i cycles (~20 ms at 32.768 kHz); legal range 2..65535.
REQ-002 Parameter TIMEOUT_CYCLES, default 327680, idle time in an edit state before abort (~10 s); legal range 16..2^20-1.
REQ-003 Parameter BLINK_CYCLES, default 8192, half-period of blink_o (~0.25 s); legal range 1..65535.
REQ-004 clk_i  input  1  32.768 kHz crystal clock, same as the watch counters.
REQ-005 rst_i  input  1  reset, asynchronous and active-high.
REQ-006 btn_mode_i  input  1  raw mode button, asynchronous, active-high.
REQ-007 btn_inc_i  input  1  raw increment button, asynchronous, active-high.
REQ-008 smode_i  input  1  safe mode; while high, editing is inhibited.
REQ-009 cfg_o  output  12  time value: [3:0] minute units 0-9, [6:4] minute tens 0-5, [11:7] hours 0-23.
REQ-010 dvalid_o  output  1  one-cycle commit strobe; cfg_o is valid in the same cycle.
REQ-011 edit_o  output  2  field being edited: 0 none, 1 hours, 2 minute tens, 3 minute units.
REQ-012 blink_o  output  1  blink enable for the display digits of the field being edited.

Function
REQ-013 Each button passes through a 2-FF synchronizer, then a debouncer; the debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles.
REQ-014 A press event is a one-cycle pulse on the debounced 0->1 edge; a release produces no event.
REQ-015 States: IDLE, SET_H, SET_MT, SET_MU, COMMIT; edit_o = 0/1/2/3/0 respectively.
REQ-016 IDLE: a mode press with smode_i low -> SET_H; working registers load from the last committed value (0 after reset).
REQ-017 SET_H: an inc press increments hours, 23 wraps to 0; a mode press -> SET_MT.
REQ-018 SET_MT: an inc press increments minute tens, 5 wraps to 0; a mode press -> SET_MU.
REQ-019 SET_MU: an inc press increments minute units, 9 wraps to 0; a mode press -> COMMIT.
REQ-020 COMMIT lasts exactly one cycle: dvalid_o = 1, cfg_o = working value, committed register updates; next state IDLE.
REQ-021 Simultaneous mode and inc presses in the same cycle: mode wins and inc is discarded.
REQ-022 Inc presses in IDLE are ignored.
REQ-023 Timeout counter clears on every press event and on state entry; when it reaches TIMEOUT_CYCLES in SET_H/SET_MT/SET_MU -> IDLE with no dvalid_o, and working registers revert to the committed value.
REQ-024 smode_i high in any edit state -> IDLE next cycle with no commit; smode_i high in IDLE blocks entry to edit mode.
REQ-025 Outside edit states cfg_o shows the committed value; in edit states it shows the working value.
REQ-026 blink_o = 0 in IDLE/COMMIT; in edit states it toggles every BLINK_CYCLES cycles, starting at 1 on each state entry.
REQ-027 Only one dvalid_o pulse per completed edit sequence; dvalid_o is never high for two consecutive cycles.
REQ-028 No counter or field ever holds an out-of-range value.

Reset
REQ-029 While rst_i is high: state IDLE, cfg_o = 0, dvalid_o = 0, edit_o = 0, blink_o = 0; synchronizers, debouncers, and the timeout and blink counters are cleared.
REQ-030 Reset asserted during an edit discards the working value; after release the block is in IDLE with committed value 0.

Verification
REQ-031 After reset, mode press; 3 inc presses; mode press; 2 inc presses; mode press; 4 inc presses; mode press -> one dvalid_o pulse with cfg_o = {5'd3, 3'd2, 4'd4}, then edit_o = 0.
REQ-032 In SET_H, 25 inc presses from 0 -> hours = 1; in SET_MU, 10 presses -> units = 0 (wrap checked).
REQ-033 Button glitch of DEB_CYCLES-1 cycles -> no event; a held press of DEB_CYCLES+2 cycles -> exactly one event.
REQ-034 In SET_MT with no presses for TIMEOUT_CYCLES -> IDLE, no dvalid_o, cfg_o returns to the prior committed value.
REQ-035 smode_i raised in SET_H -> IDLE next cycle with no commit; mode press while smode_i is high -> remains in IDLE.
REQ-036 rst_i pulsed mid-edit (SET_MU) -> all outputs 0 immediately; a subsequent mode press enters SET_H with hours = 0.

Source files
------------

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: two-button time-setting controller for a 32.768 kHz watch.
// The mode button steps through hours, minute tens and minute units, and then
// commits. The inc button advances the field that is currently selected.
// Idle timeout and safe mode both abort an edit without committing it.
`timescale 1ns/1ps

module watch_set_ctrl #(
    parameter int DEB_CYCLES     = 655,
    parameter int TIMEOUT_CYCLES = 327680,
    parameter int BLINK_CYCLES   = 8192
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        btn_mode_i,
    input  logic        btn_inc_i,
    input  logic        smode_i,
    output logic [11:0] cfg_o,
    output logic        dvalid_o,
    output logic [1:0]  edit_o,
    output logic        blink_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SET_H  = 3'd1;
    localparam logic [2:0] ST_SET_MT = 3'd2;
    localparam logic [2:0] ST_SET_MU = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] BLK_LAST = 16'(BLINK_CYCLES - 1);

    // Button bit 0 is mode and bit 1 is inc.
    logic [1:0]        sync1_q, sync1_d;
    logic [1:0]        sync2_q, sync2_d;
    logic [1:0]        deb_q, deb_d;
    logic [1:0]        deb_prev_q, deb_prev_d;
    logic [1:0][15:0]  deb_cnt_q, deb_cnt_d;

    logic [2:0]  state_q, state_d;
    logic [4:0]  hr_q, hr_d;
    logic [2:0]  mt_q, mt_d;
    logic [3:0]  mu_q, mu_d;
    logic [11:0] com_q, com_d;
    logic [19:0] tmo_q, tmo_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;

    logic [1:0]  press;
    logic        mode_ev;
    logic        inc_ev;
    logic        edit_nxt;
    logic        entry;
    logic [11:0] work;

    assign work = {hr_q, mt_q, mu_q};

    // Two-flop synchronizers for the raw asynchronous buttons.
    always_comb begin
        sync1_d = {btn_inc_i, btn_mode_i};
        sync2_d = sync1_q;
    end

    // Debounce: the level follows the input only after it has disagreed for
    // DEB_CYCLES consecutive cycles. Any agreement restarts the count.
    always_comb begin
        deb_d      = deb_q;
        deb_cnt_d  = deb_cnt_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    // Press events happen on debounced rising edges only. When both buttons
    // are pressed in the same cycle, mode takes precedence over inc.
    always_comb begin
        press   = deb_q & ~deb_prev_q;
        mode_ev = press[0];
        inc_ev  = press[1] & ~press[0];
    end

    // Edit state machine and the working/committed time registers.
    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        com_d   = com_q;
        case (state_q)
            ST_IDLE: begin
                if (mode_ev && !smode_i) begin
                    state_d            = ST_SET_H;
                    {hr_d, mt_d, mu_d} = com_q;
                end
            end
            ST_SET_H, ST_SET_MT, ST_SET_MU: begin
                if (smode_i) begin
                    state_d            = ST_IDLE;
                    {hr_d, mt_d, mu_d} = com_q;
                end else if (mode_ev) begin
                    case (state_q)
                        ST_SET_H:  state_d = ST_SET_MT;
                        ST_SET_MT: state_d = ST_SET_MU;
                        default:   state_d = ST_COMMIT;
                    endcase
                end else if (inc_ev) begin
                    case (state_q)
                        ST_SET_H:  hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                        ST_SET_MT: mt_d = (mt_q == 3'd5)  ? 3'd0 : mt_q + 3'd1;
                        default:   mu_d = (mu_q == 4'd9)  ? 4'd0 : mu_q + 4'd1;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    // Abandoned edit: the working value falls back to the committed time.
                    state_d            = ST_IDLE;
                    {hr_d, mt_d, mu_d} = com_q;
                end
            end
            ST_COMMIT: begin
                com_d   = work;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Entry into an edit state restarts both the idle timer and the blink phase.
    always_comb begin
        edit_nxt = (state_d == ST_SET_H) || (state_d == ST_SET_MT) ||
                   (state_d == ST_SET_MU);
        entry    = edit_nxt && (state_d != state_q);
    end

    // The idle timer counts only in edit states and clears on any press event.
    always_comb begin
        if (!edit_nxt || entry || (press != 2'b00)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 20'd1;
        end
    end

    // The blink phase starts at 1 on entry and toggles every BLINK_CYCLES cycles.
    always_comb begin
        if (!edit_nxt) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (entry) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + 16'd1;
        end
    end

    // State registers. Reset is asynchronous and clears everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            deb_cnt_q   <= '0;
            state_q     <= ST_IDLE;
            hr_q        <= '0;
            mt_q        <= '0;
            mu_q        <= '0;
            com_q       <= '0;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            hr_q        <= hr_d;
            mt_q        <= mt_d;
            mu_q        <= mu_d;
            com_q       <= com_d;
            tmo_q       <= tmo_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Outputs decode directly from the registered state.
    always_comb begin
        case (state_q)
            ST_SET_H:  edit_o = 2'd1;
            ST_SET_MT: edit_o = 2'd2;
            ST_SET_MU: edit_o = 2'd3;
            default:   edit_o = 2'd0;
        endcase
        dvalid_o = (state_q == ST_COMMIT);
        cfg_o    = (state_q == ST_IDLE) ? com_q : work;
        blink_o  = blink_q;
    end

endmodule
